// File: rtl/flash_block_reader_if.sv
// Bus bundle for flash_block_reader: byte-read requests toward the SPI flash
// wrapper and the packed 32-bit word stream toward the parsing stages.
interface flash_block_reader_if #(
   parameter int ADDR_W = 24
);
   logic              mem_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ready;
   logic [7:0]        mem_rdata;

   logic              m_valid;
   logic              m_ready;
   logic [31:0]       m_data;
   logic [3:0]        m_keep;
   logic              m_last;

   modport master (
      output mem_valid, mem_addr, m_valid, m_data, m_keep, m_last,
      input  mem_ready, mem_rdata, m_ready
   );

   modport slave (
      input  mem_valid, mem_addr, m_valid, m_data, m_keep, m_last,
      output mem_ready, mem_rdata, m_ready
   );
endinterface

// File: rtl/flash_block_reader.sv
// Fetches len bytes from flash at base, one wrapper request per byte, and
// streams them out packed little-endian into 32-bit words with keep/last.
module flash_block_reader #(
   parameter int ADDR_W = 24,
   parameter int LEN_W  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic [ADDR_W-1:0]    base_addr_i,
   input  logic [LEN_W-1:0]     len_i,
   output logic                 busy_o,
   output logic                 done_o,
   flash_block_reader_if.master bus
);

   typedef enum logic [2:0] {IDLE, REQ, STALL, DRAIN, DONE} state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [1:0]       idx;
   logic [31:0]      pack;
   logic [3:0]       pend_keep;
   logic             pend_last;

   logic [31:0]      word_next;
   logic [3:0]       keep_next;
   logic             last_byte;
   logic             word_done;
   logic             out_accept;
   logic             out_free;

   always_comb begin
      // NOTE: every always_comb output gets a default before any conditional
      // assignment, so no path can leave it unassigned and infer a latch.
      word_next = pack;
      word_next[8*idx +: 8] = bus.mem_rdata;
      keep_next = 4'b1111;
      case (idx)
         2'd0:    keep_next = 4'b0001;
         2'd1:    keep_next = 4'b0011;
         2'd2:    keep_next = 4'b0111;
         default: keep_next = 4'b1111;
      endcase
   end

   assign last_byte  = (remaining == LEN_W'(1));
   assign word_done  = (idx == 2'd3) || last_byte;
   assign out_accept = bus.m_valid && bus.m_ready;
   assign out_free   = !bus.m_valid || bus.m_ready;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         remaining     <= '0;
         idx           <= '0;
         pack          <= '0;
         pend_keep     <= '0;
         pend_last     <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         bus.mem_valid <= 1'b0;
         bus.mem_addr  <= '0;
         bus.m_valid   <= 1'b0;
         bus.m_data    <= '0;
         bus.m_keep    <= '0;
         bus.m_last    <= 1'b0;
      end else begin
         // NOTE: all state here uses non-blocking assignments; the later
         // assignment in this block wins, which lets a load override the
         // default clear of m_valid on acceptance without a bubble.
         done_o <= 1'b0;
         if (out_accept) begin
            bus.m_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               busy_o <= start_i;
               if (start_i) begin
                  bus.mem_addr <= base_addr_i;
                  remaining    <= len_i;
                  idx          <= '0;
                  pack         <= '0;
                  state        <= (len_i == '0) ? DONE : REQ;
               end
            end

            REQ: begin
               if (!bus.mem_valid) begin
                  bus.mem_valid <= 1'b1;
               end else if (bus.mem_ready) begin
                  bus.mem_valid <= 1'b0;
                  bus.mem_addr  <= bus.mem_addr + ADDR_W'(1);
                  remaining     <= remaining - LEN_W'(1);
                  idx           <= idx + 2'd1;
                  if (!word_done) begin
                     pack <= word_next;
                  end else if (out_free) begin
                     bus.m_data  <= word_next;
                     bus.m_keep  <= keep_next;
                     bus.m_last  <= last_byte;
                     bus.m_valid <= 1'b1;
                     pack        <= '0;
                     if (last_byte) begin
                        state <= DRAIN;
                     end
                  end else begin
                     // Output register still occupied: park the finished word.
                     pack      <= word_next;
                     pend_keep <= keep_next;
                     pend_last <= last_byte;
                     state     <= STALL;
                  end
               end
            end

            STALL: begin
               if (out_free) begin
                  bus.m_data  <= pack;
                  bus.m_keep  <= pend_keep;
                  bus.m_last  <= pend_last;
                  bus.m_valid <= 1'b1;
                  pack        <= '0;
                  state       <= pend_last ? DRAIN : REQ;
               end
            end

            DRAIN: begin
               if (out_accept) begin
                  state <= DONE;
               end
            end

            DONE: begin
               done_o <= 1'b1;
               state  <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_block_reader.sv
// Randomized scoreboard bench for flash_block_reader: a flash/wrapper model
// answers byte reads, and a monitor checks every output word against a queue.
module tb_flash_block_reader;
   localparam int ADDR_W = 24;
   localparam int LEN_W  = 16;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   logic              clk   = 1'b0;
   logic              rst   = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base  = '0;
   logic [LEN_W-1:0]  len   = '0;
   logic              busy;
   logic              done;

   flash_block_reader_if #(.ADDR_W(ADDR_W)) bus ();

   flash_block_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .base_addr_i (base),
      .len_i       (len),
      .busy_o      (busy),
      .done_o      (done),
      .bus         (bus.master)
   );

   always #5 clk = ~clk;

   int                n_checks   = 0;
   int                n_fail     = 0;
   int                req_cnt    = 0;
   int                done_cnt   = 0;
   int                ready_mode = 0;
   logic [7:0]        salt       = 8'h00;
   word_t             exp_q[$];
   word_t             acc_q[$];
   logic [ADDR_W-1:0] exp_addr[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Flash contents as seen by the bench: a simple function of the address.
   function automatic logic [7:0] flash_byte(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ 8'h5A ^ salt;
   endfunction

   task automatic push_txn(input logic [ADDR_W-1:0] b, input int n);
      word_t w;
      for (int i = 0; i < n; i++) exp_addr.push_back(b + ADDR_W'(i));
      for (int i = 0; i < n; i += 4) begin
         w = '0;
         for (int k = 0; k < 4 && i + k < n; k++) begin
            w.data[8*k +: 8] = flash_byte(b + ADDR_W'(i + k));
            w.keep[k]        = 1'b1;
         end
         w.last = (i + 4 >= n);
         exp_q.push_back(w);
      end
   endtask

   task automatic do_start(input logic [ADDR_W-1:0] b, input int n, input bit expect_run);
      @(negedge clk);
      start = 1'b1;
      base  = b;
      len   = LEN_W'(n);
      if (expect_run) push_txn(b, n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0 = done_cnt;
      int c  = 0;
      while (done_cnt == d0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      check({tag, "_done_in_time"}, done_cnt != d0, 1);
   endtask

   task automatic finish_txn(input string tag, input int r0, input int d0, input int n);
      repeat (3) @(negedge clk);
      check({tag, "_req_count"}, req_cnt - r0, n);
      check({tag, "_done_once"}, done_cnt - d0, 1);
      check({tag, "_words_left"}, exp_q.size(), 0);
      check({tag, "_addrs_left"}, exp_addr.size(), 0);
      check({tag, "_busy_low"}, busy, 0);
   endtask

   // Flash wrapper model: random latency, checks each request address.
   initial begin
      int lat = 0;
      bit in_flight = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         bus.mem_ready = 1'b0;
         bus.mem_rdata = 8'($urandom);
         if (rst || !bus.mem_valid) begin
            in_flight = 0;
         end else begin
            if (!in_flight) begin
               in_flight = 1;
               req_cnt++;
               lat = $urandom_range(0, 3);
               if (exp_addr.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_request: got addr %0h, expected none", bus.mem_addr);
               end else begin
                  check("req_addr", bus.mem_addr, exp_addr.pop_front());
               end
            end
            if (lat == 0) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = flash_byte(bus.mem_addr);
            end else begin
               lat--;
            end
         end
      end
   end

   // Downstream ready generator, changed just after each rising edge.
   initial begin
      bus.m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = ($urandom_range(0, 3) != 0);
            default: bus.m_ready = 1'b0;
         endcase
      end
   end

   // Output monitor: every presented word must match the queue head.
   initial begin
      word_t got;
      forever begin
         @(negedge clk);
         if (!rst && bus.m_valid) begin
            got = '{data: bus.m_data, keep: bus.m_keep, last: bus.m_last};
            if (exp_q.size() == 0) begin
               if (bus.m_ready) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_word: got %0h, expected none", got);
               end
            end else begin
               check("word_data", got.data, exp_q[0].data);
               check("word_keep", got.keep, exp_q[0].keep);
               check("word_last", got.last, exp_q[0].last);
               if (bus.m_ready) begin
                  acc_q.push_back(got);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},      busy,          0);
      check({tag, "_done"},      done,          0);
      check({tag, "_mem_valid"}, bus.mem_valid, 0);
      check({tag, "_mem_addr"},  bus.mem_addr,  0);
      check({tag, "_m_valid"},   bus.m_valid,   0);
      check({tag, "_m_data"},    bus.m_data,    0);
      check({tag, "_m_keep"},    bus.m_keep,    0);
      check({tag, "_m_last"},    bus.m_last,    0);
   endtask

   initial begin
      int                r0;
      int                d0;
      int                c;
      int                n;
      logic [ADDR_W-1:0] b;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Eight bytes from 0x100, always-ready sink.
      ready_mode = 0; salt = 8'h00; acc_q.delete();
      r0 = req_cnt; d0 = done_cnt;
      do_start(24'h000100, 8, 1);
      wait_done("t1", 300);
      finish_txn("t1", r0, d0, 8);
      check("t1_word_count", acc_q.size(), 2);
      if (acc_q.size() >= 2) begin
         check("t1_word0", acc_q[0].data, 32'h59585B5A);
         check("t1_word1", acc_q[1].data, 32'h5D5C5F5E);
         check("t1_keep0", acc_q[0].keep, 4'hF);
         check("t1_keep1", acc_q[1].keep, 4'hF);
         check("t1_last0", acc_q[0].last, 0);
         check("t1_last1", acc_q[1].last, 1);
      end

      // Five bytes: partial last word.
      acc_q.delete(); salt = 8'h3C;
      r0 = req_cnt; d0 = done_cnt;
      do_start(24'h012345, 5, 1);
      wait_done("t2", 300);
      finish_txn("t2", r0, d0, 5);
      check("t2_word_count", acc_q.size(), 2);
      if (acc_q.size() >= 2) begin
         check("t2_keep1",  acc_q[1].keep, 4'b0001);
         check("t2_upper0", acc_q[1].data[31:8], 0);
         check("t2_last1",  acc_q[1].last, 1);
      end

      // Zero length: done two cycles after start, no traffic.
      acc_q.delete();
      r0 = req_cnt; d0 = done_cnt;
      do_start(24'h000200, 0, 1);
      check("t3_busy_c1", busy, 1);
      check("t3_done_c1", done, 0);
      @(negedge clk);
      check("t3_done_c2", done, 1);
      check("t3_busy_c2", busy, 1);
      @(negedge clk);
      check("t3_done_c3", done, 0);
      check("t3_busy_c3", busy, 0);
      repeat (3) @(negedge clk);
      check("t3_req_count", req_cnt - r0, 0);
      check("t3_no_words", acc_q.size(), 0);
      check("t3_done_once", done_cnt - d0, 1);

      // Address wrap at the top of flash.
      acc_q.delete();
      r0 = req_cnt; d0 = done_cnt;
      do_start(24'hFFFFFE, 4, 1);
      wait_done("t4", 300);
      finish_txn("t4", r0, d0, 4);
      check("t4_word_count", acc_q.size(), 1);

      // Sink stalled: reader must stop after two words' worth of reads.
      ready_mode = 2; acc_q.delete();
      r0 = req_cnt; d0 = done_cnt;
      do_start(24'h00A000, 12, 1);
      repeat (50) @(negedge clk);
      check("t5_reads_le_8", (req_cnt - r0) <= 8, 1);
      check("t5_mem_idle", bus.mem_valid, 0);
      check("t5_m_valid", bus.m_valid, 1);
      if (exp_q.size() > 0) check("t5_held_data", bus.m_data, exp_q[0].data);
      ready_mode = 0;
      wait_done("t5", 300);
      finish_txn("t5", r0, d0, 12);
      check("t5_word_count", acc_q.size(), 3);

      // Reset in the middle of a word, then a clean run with an ignored start.
      r0 = req_cnt;
      do_start(24'h004000, 8, 1);
      c = 0;
      while (!((req_cnt - r0) >= 2 && bus.mem_valid) && c < 200) begin
         @(negedge clk);
         c++;
      end
      check("t6_mid_word_reached", c < 200, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("t6_reset");
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete(); exp_addr.delete(); acc_q.delete();
      d0 = done_cnt;
      repeat (5) @(negedge clk);
      check("t6_no_done_after_reset", done_cnt - d0, 0);
      r0 = req_cnt;
      do_start(24'h007770, 6, 1);
      repeat (3) @(negedge clk);
      do_start(24'h00BEEF, 9, 0);
      wait_done("t6", 300);
      finish_txn("t6", r0, d0, 6);
      check("t6_word_count", acc_q.size(), 2);

      // Randomized transfers against a randomly stalling sink.
      ready_mode = 1;
      for (int t = 0; t < 25; t++) begin
         salt = 8'($urandom);
         b    = ADDR_W'($urandom);
         n    = $urandom_range(0, 23);
         r0   = req_cnt; d0 = done_cnt;
         do_start(b, n, 1);
         wait_done("rand", n * 16 + 60);
         finish_txn("rand", r0, d0, n);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
